prescaler_tick_gen: RTL and testbench

//  Programmable clock-enable generator. Sits directly upstream of the 5-bit counter
//  and drives its count enable with a one-cycle tick every (P+1) clock cycles.
//  P is loaded through a valid/ready config port. While running, a new P is held in
//  a shadow register and takes effect only at a terminal count, so no period is ever

---
 rtl/prescaler_tick_gen.sv | 123 ++++++++++++
 tb/tb_prescaler_tick_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaler_tick_gen.sv
// Programmable clock-enable generator: emits a one-cycle tick every (P+1) cycles.
// P arrives over a valid/ready config port. While running, a new P is parked in a
// shadow register and committed only at a terminal count, so no period is truncated.
// Build option: define PRESCALER_TICK_SAT_EN to make tick_count saturate instead of wrap.
module prescaler_tick_gen #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TICK_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_prescaler,
  input  logic                  cfg_oneshot,
  input  logic                  start,
  input  logic                  stop,
  output logic                  tick,
  output logic                  busy,
  output logic [TICK_CNT_W-1:0] tick_count
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q;
  logic [WIDTH-1:0]      div_q;
  logic [WIDTH-1:0]      act_p_q;
  logic [WIDTH-1:0]      shadow_p_q;
  logic                  act_os_q;
  logic                  shadow_os_q;
  logic                  pend_q;
  logic [TICK_CNT_W-1:0] tick_cnt_q;

  logic                  cfg_acc;
  logic                  commit;
  logic [WIDTH-1:0]      next_p;
  logic [TICK_CNT_W-1:0] tick_cnt_inc;

  // Outputs are decoded purely from registers; no combinational input path.
  always_comb begin
    tick       = (state_q == StRun) && (div_q == '0);
    busy       = (state_q == StRun);
    cfg_ready  = !pend_q;
    tick_count = tick_cnt_q;
    cfg_acc    = cfg_valid && cfg_ready;
    // A pending shadow value takes over at the edge closing a tick cycle.
    commit     = tick && pend_q;
    next_p     = commit ? shadow_p_q : act_p_q;
  end

  // Tick counter arithmetic: saturating or wrapping depending on the build.
  always_comb begin
`ifdef PRESCALER_TICK_SAT_EN
    tick_cnt_inc = (&tick_cnt_q) ? tick_cnt_q : tick_cnt_q + 1'b1;
`else
    tick_cnt_inc = tick_cnt_q + 1'b1;
`endif
  end

  // Control FSM, divider, config registers and tick counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      div_q       <= '0;
      act_p_q     <= '0;
      shadow_p_q  <= '0;
      act_os_q    <= 1'b0;
      shadow_os_q <= 1'b0;
      pend_q      <= 1'b0;
      tick_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_acc) begin
            act_p_q  <= cfg_prescaler;
            act_os_q <= cfg_oneshot;
          end
          // Stop wins over start; a config accepted this cycle is used for this start.
          if (start && !stop) begin
            state_q    <= StRun;
            div_q      <= cfg_acc ? cfg_prescaler : act_p_q;
            tick_cnt_q <= '0;
          end
        end
        StRun: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_inc;
          end
          if (stop || (tick && act_os_q)) begin
            state_q <= StIdle;
            div_q   <= '0;
            // Leaving RUN: fold any pending or just-accepted config into the active set
            // so IDLE never holds a stale shadow with cfg_ready low.
            if (pend_q) begin
              act_p_q  <= shadow_p_q;
              act_os_q <= shadow_os_q;
              pend_q   <= 1'b0;
            end else if (cfg_acc) begin
              act_p_q  <= cfg_prescaler;
              act_os_q <= cfg_oneshot;
            end
          end else begin
            if (commit) begin
              act_p_q  <= shadow_p_q;
              act_os_q <= shadow_os_q;
              pend_q   <= 1'b0;
            end else if (cfg_acc) begin
              shadow_p_q  <= cfg_prescaler;
              shadow_os_q <= cfg_oneshot;
              pend_q      <= 1'b1;
            end
            if (start || tick) begin
              div_q <= next_p;
            end else begin
              div_q <= div_q - 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prescaler_tick_gen.sv
// Directed bench for prescaler_tick_gen. A second instance with a 4-bit tick counter
// shares all inputs and is used for the counter wrap/saturate boundary.
module tb_prescaler_tick_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_prescaler;
  logic        cfg_oneshot;
  logic        start;
  logic        stop;
  logic        tick;
  logic        busy;
  logic [15:0] tick_count;

  logic        cfg_ready4;
  logic        tick4;
  logic        busy4;
  logic [3:0]  tick_count4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  prescaler_tick_gen #(.WIDTH(32), .TICK_CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_prescaler (cfg_prescaler),
    .cfg_oneshot   (cfg_oneshot),
    .start         (start),
    .stop          (stop),
    .tick          (tick),
    .busy          (busy),
    .tick_count    (tick_count)
  );

  prescaler_tick_gen #(.WIDTH(32), .TICK_CNT_W(4)) dut4 (
    .clock         (clock),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready4),
    .cfg_prescaler (cfg_prescaler),
    .cfg_oneshot   (cfg_oneshot),
    .start         (start),
    .stop          (stop),
    .tick          (tick4),
    .busy          (busy4),
    .tick_count    (tick_count4)
  );

  // Advance to just after the next rising edge; inputs driven here meet the following edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input logic [31:0] p, input logic os);
    cfg_valid     = 1'b1;
    cfg_prescaler = p;
    cfg_oneshot   = os;
    cyc();
    cfg_valid     = 1'b0;
  endtask

  // Start pulse; returns in the cycle after edge E0.
  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n_vec++;
    if (tick !== 1'b0) begin n_err++; $display("FAIL por_tick: got %b want 0", tick); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL por_busy: got %b want 0", busy); end
    n_vec++;
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL por_ready: got %b want 1", cfg_ready); end
    n_vec++;
    if (tick_count !== 16'd0) begin
      n_err++; $display("FAIL por_count: got %0d want 0", tick_count);
    end
    // Reset in the middle of a P=5 run with a shadow update pending.
    do_cfg(32'd5, 1'b0);
    do_start();
    cyc();
    do_cfg(32'd2, 1'b0);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n_vec++;
    if (tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || tick_count !== 16'd0) begin
      n_err++;
      $display("FAIL midrun_reset: got tick=%b busy=%b ready=%b cnt=%0d want 0 0 1 0",
               tick, busy, cfg_ready, tick_count);
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_vec++;
      if (tick !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL reset_idle_%0d: got tick=%b busy=%b want 0 0", i, tick, busy);
      end
    end
  endtask

  task automatic test_periodic();
    int cnt;
    logic exp_t;
    do_cfg(32'd3, 1'b0);
    do_start();
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp_t = ((i % 4) == 3);
      n_vec++;
      if (tick !== exp_t || tick_count !== cnt[15:0]) begin
        n_err++;
        $display("FAIL periodic_E%0d: got tick=%b cnt=%0d want %b %0d", i, tick, tick_count,
                 exp_t, cnt);
      end
      if (exp_t) cnt++;
    end
    do_stop();
    n_vec++;
    if (busy !== 1'b0 || tick !== 1'b0 || tick_count !== 16'd3) begin
      n_err++;
      $display("FAIL periodic_stop: got busy=%b tick=%b cnt=%0d want 0 0 3", busy, tick,
               tick_count);
    end
  endtask

  task automatic test_p_zero();
    do_cfg(32'd0, 1'b0);
    do_start();
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (tick !== 1'b1) begin n_err++; $display("FAIL p0_tick_%0d: got %b want 1", i, tick); end
      cyc();
    end
    n_vec++;
    if (tick_count !== 16'd10) begin
      n_err++; $display("FAIL p0_count: got %0d want 10", tick_count);
    end
    do_stop();
    n_vec++;
    if (tick !== 1'b0 || busy !== 1'b0 || tick_count !== 16'd11) begin
      n_err++;
      $display("FAIL p0_stop: got tick=%b busy=%b cnt=%0d want 0 0 11", tick, busy, tick_count);
    end
  endtask

  task automatic test_shadow();
    logic [10:1] exp_t;
    logic [10:1] exp_r;
    exp_t = 10'b1010101000;
    exp_r = 10'b1111110000;
    do_cfg(32'd4, 1'b0);
    do_start();
    // Accepted at E1, one cycle into a 5-cycle period.
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL shadow_ready_pre: got %b want 1", cfg_ready);
    end
    do_cfg(32'd1, 1'b0);
    n_vec++;
    if (tick !== exp_t[1] || cfg_ready !== exp_r[1]) begin
      n_err++;
      $display("FAIL shadow_E1: got tick=%b ready=%b want %b %b", tick, cfg_ready, exp_t[1],
               exp_r[1]);
    end
    for (int i = 2; i <= 10; i++) begin
      cyc();
      n_vec++;
      if (tick !== exp_t[i] || cfg_ready !== exp_r[i]) begin
        n_err++;
        $display("FAIL shadow_E%0d: got tick=%b ready=%b want %b %b", i, tick, cfg_ready,
                 exp_t[i], exp_r[i]);
      end
    end
    do_stop();
  endtask

  task automatic test_oneshot();
    do_cfg(32'd2, 1'b1);
    do_start();
    for (int i = 1; i <= 6; i++) begin
      cyc();
      n_vec++;
      if (tick !== (i == 2) || busy !== (i <= 2)) begin
        n_err++;
        $display("FAIL oneshot_E%0d: got tick=%b busy=%b want %b %b", i, tick, busy, (i == 2),
                 (i <= 2));
      end
    end
    n_vec++;
    if (tick_count !== 16'd1) begin
      n_err++; $display("FAIL oneshot_count: got %0d want 1", tick_count);
    end
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL start_stop_%0d: got busy=%b want 0", i, busy);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Config and start in the same cycle: the new P=1 governs this run.
    cfg_valid     = 1'b1;
    cfg_prescaler = 32'd1;
    cfg_oneshot   = 1'b0;
    start         = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    start     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_vec++;
      if (tick !== ((i % 2) == 1)) begin
        n_err++; $display("FAIL cfg_start_E%0d: got %b want %b", i, tick, ((i % 2) == 1));
      end
    end
    // Now after E4 (div=1); restart at E5 reloads the full period and keeps tick_count.
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_vec++;
    if (tick !== 1'b0 || tick_count !== 16'd2 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart: got tick=%b cnt=%0d busy=%b want 0 2 1", tick, tick_count, busy);
    end
    cyc();
    n_vec++;
    if (tick !== 1'b1) begin n_err++; $display("FAIL restart_tick: got %b want 1", tick); end
    do_stop();
    n_vec++;
    if (tick_count !== 16'd3) begin
      n_err++; $display("FAIL restart_count: got %0d want 3", tick_count);
    end
  endtask

  task automatic test_count_limit();
    logic [3:0] exp4;
`ifdef PRESCALER_TICK_SAT_EN
    exp4 = 4'd15;
`else
    exp4 = 4'd4;
`endif
    do_cfg(32'd0, 1'b0);
    do_start();
    for (int i = 0; i < 20; i++) cyc();
    n_vec++;
    if (tick_count4 !== exp4) begin
      n_err++; $display("FAIL count4: got %0d want %0d", tick_count4, exp4);
    end
    n_vec++;
    if (tick_count !== 16'd20) begin
      n_err++; $display("FAIL count16: got %0d want 20", tick_count);
    end
    do_stop();
  endtask

  initial begin
    reset         = 1'b1;
    cfg_valid     = 1'b0;
    cfg_prescaler = '0;
    cfg_oneshot   = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    test_reset();
    test_periodic();
    test_p_zero();
    test_shadow();
    test_oneshot();
    test_back_to_back();
    test_count_limit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
